// File: rtl/feed_forward_layer_scheduler.sv
// feed_forward_layer_scheduler: time-shares one node datapath across a layer and writes results to RAM
module feed_forward_layer_scheduler #(
  parameter int DATA_WIDTH            = 32,
  parameter int ADDRESS_WIDTH         = 5,
  parameter int NUMBER_OF_OUTPUT_NODE = 4,
  parameter int TIMEOUT_CYCLES        = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic                     o_node_valid,
  output logic [ADDRESS_WIDTH-1:0] o_node_address,
  input  logic [DATA_WIDTH-1:0]    i_node_data,
  input  logic                     i_node_valid,
  output logic                     o_write,
  output logic [ADDRESS_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic                     o_valid,
  output logic                     o_error
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE, ERROR} state_t;
  localparam logic [ADDRESS_WIDTH-1:0] LAST  = ADDRESS_WIDTH'(NUMBER_OF_OUTPUT_NODE - 1);
  localparam logic [15:0]              TLAST = 16'(TIMEOUT_CYCLES - 1);
  state_t                   state, state_n;
  logic [ADDRESS_WIDTH-1:0] cnt, cnt_n, addr_q, addr_n;
  logic [DATA_WIDTH-1:0]    data_q, data_n;
  logic [15:0]              timer, timer_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      timer  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      timer  <= timer_n;
      addr_q <= addr_n;
      data_q <= data_n;
    end
  // Result and write address are captured together so the RAM port holds them between writes
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    timer_n = timer;
    addr_n  = addr_q;
    data_n  = data_q;
    case (state)
      IDLE: if (i_valid) begin
        cnt_n   = '0;
        state_n = ISSUE;
      end
      ISSUE: begin
        timer_n = '0;
        state_n = WAIT;
      end
      WAIT: if (i_node_valid) begin
        data_n  = i_node_data;
        addr_n  = cnt;
        state_n = WRITE;
      end else begin
        timer_n = timer + 16'd1;
        state_n = timer == TLAST ? ERROR : WAIT;
      end
      WRITE: begin
        cnt_n   = cnt == LAST ? cnt : cnt + 1'b1;
        state_n = cnt == LAST ? DONE : ISSUE;
      end
      DONE:    state_n = IDLE;
      ERROR:   state_n = ERROR;
      default: state_n = IDLE;
    endcase
  end
  assign o_ready        = state == IDLE;
  assign o_node_valid   = state == ISSUE;
  assign o_write        = state == WRITE;
  assign o_valid        = state == DONE;
  assign o_error        = state == ERROR;
  assign o_node_address = cnt;
  assign o_address      = addr_q;
  assign o_data         = data_q;
endmodule

// File: tb/tb_feed_forward_layer_scheduler.sv
// tb_feed_forward_layer_scheduler: table, random and corner-case checks against a timing model of the layer
module tb_feed_forward_layer_scheduler;
  localparam int DW = 32, AW = 5, N = 4, T = 8;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic i_valid = 0, i_node_valid = 0;
  logic [DW-1:0] i_node_data = '0;
  logic o_ready, o_node_valid, o_write, o_valid, o_error;
  logic [AW-1:0] o_node_address, o_address;
  logic [DW-1:0] o_data;
  logic v1 = 0, nv1 = 0;
  logic [DW-1:0] d1 = '0;
  logic r1, nvo1, w1, ov1, e1;
  logic [AW-1:0] na1, a1;
  logic [DW-1:0] dd1;
  int checks = 0, errors = 0;
  logic [DW-1:0] dat [4];

  feed_forward_layer_scheduler #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUMBER_OF_OUTPUT_NODE(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .o_node_valid(o_node_valid),
    .o_node_address(o_node_address), .i_node_data(i_node_data), .i_node_valid(i_node_valid),
    .o_write(o_write), .o_address(o_address), .o_data(o_data), .o_valid(o_valid), .o_error(o_error));

  feed_forward_layer_scheduler #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUMBER_OF_OUTPUT_NODE(1), .TIMEOUT_CYCLES(T)) dut1 (
    .clk(clk), .rst(rst), .i_valid(v1), .o_ready(r1), .o_node_valid(nvo1),
    .o_node_address(na1), .i_node_data(d1), .i_node_valid(nv1),
    .o_write(w1), .o_address(a1), .o_data(dd1), .o_valid(ov1), .o_error(e1));

  typedef struct packed {
    logic [3:0][7:0] lat;
    logic            busy;
    logic [7:0]      want_wr;
    logic [7:0]      want_lat;
    logic            want_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0][7:0] pack_lat(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic do_reset();
    rst = 1;
    #1;
    chk("rst_ready", o_ready, 1);
    chk("rst_node_valid", o_node_valid, 0);
    chk("rst_write", o_write, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_error", o_error, 0);
    chk("rst_node_addr", o_node_address, 0);
    chk("rst_addr", o_address, 0);
    chk("rst_data", o_data, 0);
    #1;
    rst = 0;
    i_valid = 0;
    i_node_valid = 0;
    @(posedge clk); #1;
  endtask

  // Model: node i issues at s_i, waits lat[i] cycles, writes at s_i+lat+1; late/silent nodes trip the watchdog T cycles into WAIT
  task automatic run_layer(input logic [3:0][7:0] lat, input bit busy, input int want_wr, input int want_lat, input int want_err);
    int s, n_exp, exp_done, exp_err, nw, nd, resp_c, err_c, done_c, last;
    int exp_wc [4];
    s = 0; n_exp = 0; exp_done = -1; exp_err = -1;
    for (int i = 0; i < N; i++) begin
      exp_wc[i] = -1;
      if (exp_err < 0) begin
        if (int'(lat[i]) > T) exp_err = s + 1 + T;
        else begin
          exp_wc[i] = s + int'(lat[i]) + 1;
          n_exp++;
          s += int'(lat[i]) + 2;
        end
      end
    end
    if (exp_err < 0) exp_done = s;
    last = (exp_done >= 0 ? exp_done : exp_err) + 3;
    nw = 0; nd = 0; resp_c = -1; err_c = -1; done_c = -1;
    i_valid = 1;
    @(posedge clk); #1;
    for (int c = 0; c <= last; c++) begin
      i_valid = busy && c == 2;
      if (o_node_valid) resp_c = c + int'(lat[o_node_address[1:0]]);
      i_node_valid = c == resp_c;
      i_node_data = dat[o_node_address[1:0]];
      chk("ready", o_ready, exp_done >= 0 && c > exp_done);
      if (o_write) begin
        if (nw < N) begin
          chk("wr_cycle", c, exp_wc[nw]);
          chk("wr_addr", o_address, nw);
          chk("wr_data", o_data, dat[nw]);
        end
        nw++;
      end
      if (o_valid) begin
        chk("done_cycle", c, exp_done);
        done_c = c;
        nd++;
      end
      if (o_error && err_c < 0) begin
        err_c = c;
        chk("err_cycle", c, exp_err);
      end
      if (err_c >= 0) chk("err_sticky", o_error, 1);
      @(posedge clk); #1;
    end
    i_valid = 0;
    i_node_valid = 0;
    chk("writes_model", nw, n_exp);
    chk("done_count", nd, exp_done >= 0);
    chk("error_model", o_error, exp_err >= 0);
    if (want_wr >= 0) begin
      chk("writes_tbl", nw, want_wr);
      chk("latency_tbl", done_c + 1, want_lat);
      chk("error_tbl", o_error, want_err);
    end
  endtask

  vec_t tbl [6];
  bit hit;
  int resp;

  initial begin
    tbl[0] = '{pack_lat(3, 3, 3, 3), 1'b0, 8'd4, 8'd21, 1'b0};
    tbl[1] = '{pack_lat(3, 3, 3, 3), 1'b1, 8'd4, 8'd21, 1'b0};
    tbl[2] = '{pack_lat(8, 8, 8, 8), 1'b0, 8'd4, 8'd41, 1'b0};
    tbl[3] = '{pack_lat(1, 2, 200, 1), 1'b0, 8'd2, 8'd0, 1'b1};
    tbl[4] = '{pack_lat(1, 1, 1, 1), 1'b0, 8'd4, 8'd13, 1'b0};
    tbl[5] = '{pack_lat(9, 1, 1, 1), 1'b0, 8'd0, 8'd0, 1'b1};
    for (int i = 0; i < 4; i++) dat[i] = 32'h3F80_0000 + DW'(i);
    do_reset();
    chk("rst1_ready", r1, 1);
    chk("rst1_write", w1, 0);
    for (int i = 0; i < 6; i++) begin
      run_layer(tbl[i].lat, tbl[i].busy, int'(tbl[i].want_wr), int'(tbl[i].want_lat), int'(tbl[i].want_err));
      if (o_error) begin
        chk("err_no_ready", o_ready, 0);
        do_reset();
      end
    end
    // Reset asserted while node 1 is being written
    i_valid = 1;
    @(posedge clk); #1;
    i_valid = 0;
    hit = 0; resp = -1;
    for (int c = 0; c < 30 && !hit; c++) begin
      if (o_node_valid) resp = c + 3;
      i_node_valid = c == resp;
      i_node_data = dat[o_node_address[1:0]];
      if (o_write && o_address == 1) hit = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("reached_write1", hit, 1);
    do_reset();
    for (int c = 0; c < 5; c++) begin
      chk("post_rst_valid", o_valid, 0);
      chk("post_rst_ready", o_ready, 1);
      @(posedge clk); #1;
    end
    run_layer(pack_lat(3, 3, 3, 3), 1'b0, 4, 21, 0);
    // Randomized layers against the model
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 4; i++) dat[i] = $urandom;
      run_layer(pack_lat($urandom_range(1, 9), $urandom_range(1, 9), $urandom_range(1, 9), $urandom_range(1, 9)),
                1'($urandom_range(0, 1)), -1, 0, 0);
      if (o_error) do_reset();
    end
    // Single-node layer with stray result strobes in IDLE and ISSUE
    d1 = 32'h4049_0FDB;
    nv1 = 1;
    @(posedge clk); #1;
    nv1 = 0;
    chk("n1_idle_stray_write", w1, 0);
    chk("n1_idle_stray_ready", r1, 1);
    v1 = 1;
    @(posedge clk); #1;
    v1 = 0;
    chk("n1_issue", nvo1, 1);
    chk("n1_issue_addr", na1, 0);
    nv1 = 1;
    @(posedge clk); #1;
    chk("n1_wait_no_write", w1, 0);
    @(posedge clk); #1;
    nv1 = 0;
    chk("n1_write", w1, 1);
    chk("n1_write_addr", a1, 0);
    chk("n1_write_data", dd1, 32'h4049_0FDB);
    @(posedge clk); #1;
    chk("n1_done", ov1, 1);
    @(posedge clk); #1;
    chk("n1_ready_again", r1, 1);
    chk("n1_done_once", ov1, 0);
    chk("n1_no_error", e1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/feed_forward_layer_scheduler.md
# feed_forward_layer_scheduler

Sequencer that computes a full layer of the Q/target network by time-sharing one `feed_forward_node` datapath across `NUMBER_OF_OUTPUT_NODE` neurons. On a layer start it issues each node address in turn, waits for the datapath result, and writes it into the next layer's input RAM. It then signals layer completion. A watchdog flags a datapath that never answers.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of one IEEE-754 single-precision result.
- `ADDRESS_WIDTH`, 5: width of node and RAM addresses.
- `NUMBER_OF_OUTPUT_NODE`, 4: nodes per layer. Legal range is 1 to 2^ADDRESS_WIDTH.
- `TIMEOUT_CYCLES`, 64: maximum cycles spent waiting for one node result. Legal range is 1 to 65535.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `i_valid`, input, 1: layer start request. Sampled only in IDLE.
- `o_ready`, output, 1: high in IDLE only.
- `o_node_valid`, output, 1: one-cycle start pulse to the datapath.
- `o_node_address`, output, ADDRESS_WIDTH: node being computed. Maps to the datapath `ADDRESS_NODE`.
- `i_node_data`, input, DATA_WIDTH: datapath result.
- `i_node_valid`, input, 1: datapath result strobe.
- `o_write`, output, 1: RAM write enable.
- `o_address`, output, ADDRESS_WIDTH: RAM write address.
- `o_data`, output, DATA_WIDTH: RAM write data.
- `o_valid`, output, 1: one-cycle layer-done pulse.
- `o_error`, output, 1: sticky watchdog error.

## Operation
- FSM states: IDLE, ISSUE, WAIT, WRITE, DONE, ERROR. All outputs are registered or decoded from registered state only; there is no input-to-output combinational path.
- **IDLE**:
  - `o_ready`=1.
  - When `i_valid`=1, clear the node counter to 0 and go to ISSUE.
- **ISSUE**:
  - `o_node_valid`=1 and `o_node_address`=counter.
  - Clear the watchdog timer and go to WAIT.
- **WAIT**:
  - When `i_node_valid`=1, capture `i_node_data` into the result register and go to WRITE.
  - Otherwise increment the timer. If the timer equals TIMEOUT_CYCLES-1, go to ERROR.
  - If `i_node_valid` arrives on the timeout cycle, the data wins and the FSM goes to WRITE.
- **WRITE**:
  - `o_write`=1, `o_address`=counter, `o_data`=captured result.
  - If counter = NUMBER_OF_OUTPUT_NODE-1, go to DONE. Otherwise increment the counter and go to ISSUE.
- **DONE**: `o_valid`=1, then go to IDLE.
- **ERROR**:
  - `o_error`=1 and `o_ready`=0.
  - Stays in ERROR until `rst`. No writes or pulses are issued.
- `i_valid` outside IDLE is ignored and is not queued.
- `i_node_valid` outside WAIT is ignored, including in the ISSUE cycle itself.
- `o_node_address` holds the current counter value from ISSUE through WRITE.
- `o_data` and `o_address` keep their last written values between writes.
- The counter is ADDRESS_WIDTH bits and never wraps: the terminal compare uses NUMBER_OF_OUTPUT_NODE-1.
- The timer is 16 bits.

## Timing
- Reset values:
  - state = IDLE, `o_ready`=1.
  - `o_node_valid`, `o_write`, `o_valid`, `o_error` = 0.
  - `o_node_address`, `o_address`, `o_data`, counter, timer = 0.
- Reset mid-layer aborts immediately and asynchronously: all outputs return to reset values. No partial DONE is reported.
- For `i_valid` sampled at edge k:
  - ISSUE is active in cycle k+1, so `o_node_valid` is high between edges k+1 and k+2.
  - For a datapath that asserts `i_node_valid` L≥1 cycles after sampling `o_node_valid`, each node takes L+2 cycles: ISSUE, then L WAIT cycles, then WRITE.
- Full layer latency from `i_valid` edge to the `o_valid` edge is N·(L+2)+1 cycles.
- `o_ready` drops in the cycle after the start request is accepted. It rises again in the cycle after DONE.
- With TIMEOUT_CYCLES=T and no response, ERROR is entered T cycles after entering WAIT.

## Test plan
- **Normal layer.** Setup: N=4, mock datapath with L=3 returning 0x3F800000+address.
  - Writes go to addresses 0,1,2,3 with data 0x3F800000..0x3F800003, spaced 5 cycles apart.
  - `o_valid` pulses once, 21 cycles after start.
  - `o_ready` returns to 1.
- **Start while busy.** Pulse `i_valid` again during WAIT.
  - Exactly 4 writes and one `o_valid` occur.
  - A new request in IDLE afterwards starts a fresh layer at address 0.
- **Watchdog timeout.** Setup: T=8, datapath silent for node 2.
  - Writes occur at addresses 0 and 1 only.
  - `o_error` rises 8 cycles after WAIT entry and stays high.
  - `o_ready`=0 and no `o_valid`.
  - `rst` clears everything.
- **Boundary timeout.** Setup: T=8, datapath answers exactly on the 8th WAIT cycle.
  - The write occurs and `o_error` stays 0.
- **Reset mid-layer.** Assert `rst` during WRITE of node 1.
  - All outputs are immediately at reset values.
  - No `o_valid`. The next start writes address 0 first.
- **Degenerate layer.** Setup: N=1, L=1.
  - One write to address 0.
  - `o_valid` 4 cycles after start.
  - Stray `i_node_valid` pulses in ISSUE or IDLE are ignored.
